// File: rtl/upc_loop_profiler.sv
`timescale 1ns/1ps
// upc_loop_profiler
// Watches one monitored accelerator top and records its transactions. Each
// ap_start..ap_done span is one transaction. For each span it measures the
// latency in cycles, the number of completed loop iterations and the number
// of stalled cycles. Closed transactions go into a small record FIFO, which
// a consumer drains with a valid/ready handshake. A finish request closes
// any open transaction as partial and drains the FIFO. The profiler then
// parks in DONE until reset.
module upc_loop_profiler #(
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             iter_end,
  input  logic             stall,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_txn_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_iters,
  output logic [CNT_W-1:0] rec_stalls,
  output logic             rec_partial,
  output logic [15:0]      overflow_cnt,
  output logic             busy,
  output logic             all_done
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = 16 + 3 * CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Saturating increment for the statistic counters.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic             en);
    if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  // Saturating increment for the 16-bit drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v,
                                            input logic        en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_lat;
  logic [CNT_W-1:0]   r_iters;
  logic [CNT_W-1:0]   r_stalls;
  logic [15:0]        r_txn;
  logic [15:0]        r_overflow;
  logic               r_busy;
  logic               r_all_done;

  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic [REC_W-1:0]   r_mem [FIFO_DEPTH];

  logic [CNT_W-1:0]   w_lat_nxt;
  logic [CNT_W-1:0]   w_iters_nxt;
  logic [CNT_W-1:0]   w_stalls_nxt;
  logic               w_load;
  logic               w_push;
  logic               w_partial;
  logic               w_txn_inc;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_accept;
  logic               w_drop;
  logic [REC_W-1:0]   w_rec;
  logic [REC_W-1:0]   w_head;

  // The record always uses counts that include the current cycle. Events
  // that arrive together with ap_done or finish are therefore captured.
  assign w_lat_nxt    = sat_inc_cnt(r_lat, 1'b1);
  assign w_iters_nxt  = sat_inc_cnt(r_iters, iter_end);
  assign w_stalls_nxt = sat_inc_cnt(r_stalls, stall);

  // FIFO occupancy. The pointers carry one extra wrap bit, so full and
  // empty can be told apart.
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = !w_empty && rec_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && !w_accept;

  assign w_rec  = {r_txn, w_lat_nxt, w_iters_nxt, w_stalls_nxt, w_partial};
  assign w_head = r_mem[r_rptr[AW-1:0]];

  // Next-state and record-push decode; finish wins over a start in IDLE
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_push    = 1'b0;
    w_partial = 1'b0;
    w_txn_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (finish) begin
          w_next = S_FLUSH;
        end else if (ap_start) begin
          w_next = S_ACTIVE;
          w_load = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (ap_done) begin
          w_push    = 1'b1;
          w_txn_inc = 1'b1;
          w_next    = finish ? S_FLUSH : S_IDLE;
        end else if (finish) begin
          w_push    = 1'b1;
          w_partial = 1'b1;
          w_next    = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_empty) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register plus the registered status flags that mirror it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == S_ACTIVE);
      r_all_done <= (w_next == S_DONE);
    end
  end

  // Per-transaction counters: the start cycle counts as latency 1
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lat    <= '0;
      r_iters  <= '0;
      r_stalls <= '0;
    end else if (w_load) begin
      r_lat    <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_iters  <= '0;
      r_stalls <= '0;
    end else if (r_state == S_ACTIVE) begin
      r_lat    <= w_lat_nxt;
      r_iters  <= w_iters_nxt;
      r_stalls <= w_stalls_nxt;
    end
  end

  // Transaction index (wraps) and saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_txn      <= '0;
      r_overflow <= '0;
    end else begin
      if (w_txn_inc) r_txn <= r_txn + 16'd1;
      r_overflow <= sat_inc16(r_overflow, w_drop);
    end
  end

  // FIFO pointers; a push on a full FIFO is taken only alongside a pop
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until a pointer exposes them
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wptr[AW-1:0]] <= w_rec;
  end

  // Head entry is shown only while valid, so an empty FIFO reads as zeros.
  assign rec_valid = !w_empty;
  assign {rec_txn_id, rec_latency, rec_iters, rec_stalls, rec_partial} =
    rec_valid ? w_head : '0;

  assign overflow_cnt = r_overflow;
  assign busy         = r_busy;
  assign all_done     = r_all_done;

endmodule

// File: tb/tb_upc_loop_profiler.sv
`timescale 1ns/1ps
// Bench for upc_loop_profiler. The stimulus tasks push the expected records
// into a queue as they drive each closing event. A negedge monitor compares
// the presented head record against the front of the queue on every valid
// cycle, and pops the queue on a handshake.
module tb_upc_loop_profiler;

  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam logic [CW-1:0] MAXV = '1;

  logic          clock     = 1'b0;
  logic          reset     = 1'b1;
  logic          ap_start  = 1'b0;
  logic          ap_done   = 1'b0;
  logic          iter_end  = 1'b0;
  logic          stall     = 1'b0;
  logic          finish    = 1'b0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [15:0]   rec_txn_id;
  logic [CW-1:0] rec_latency;
  logic [CW-1:0] rec_iters;
  logic [CW-1:0] rec_stalls;
  logic          rec_partial;
  logic [15:0]   overflow_cnt;
  logic          busy;
  logic          all_done;

  typedef struct {
    logic [15:0]   id;
    logic [CW-1:0] lat;
    logic [CW-1:0] it;
    logic [CW-1:0] st;
    logic          partial;
  } rec_t;

  rec_t        q[$];
  logic [15:0] exp_id = '0;
  int          n_chk  = 0;
  int          n_fail = 0;

  upc_loop_profiler #(.CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
    .iter_end(iter_end), .stall(stall), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_txn_id(rec_txn_id),
    .rec_latency(rec_latency), .rec_iters(rec_iters), .rec_stalls(rec_stalls),
    .rec_partial(rec_partial), .overflow_cnt(overflow_cnt), .busy(busy),
    .all_done(all_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head record vs scoreboard front; holds under backpressure are rechecked
  always @(negedge clock) begin
    if (rec_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_rec_valid", {63'd0, rec_valid}, 64'd0);
      end else begin
        chk("rec_txn_id",  64'(rec_txn_id),  64'(q[0].id));
        chk("rec_latency", 64'(rec_latency), 64'(q[0].lat));
        chk("rec_iters",   64'(rec_iters),   64'(q[0].it));
        chk("rec_stalls",  64'(rec_stalls),  64'(q[0].st));
        chk("rec_partial", 64'(rec_partial), 64'(q[0].partial));
        if (rec_ready) void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ap_start = 1'b0; ap_done = 1'b0; iter_end = 1'b0;
    stall = 1'b0; finish = 1'b0; rec_ready = 1'b0;
    tick();
    tick();
    q.delete();
    exp_id = '0;
    chk("rst_rec_valid",  64'(rec_valid),    64'd0);
    chk("rst_busy",       64'(busy),         64'd0);
    chk("rst_all_done",   64'(all_done),     64'd0);
    chk("rst_overflow",   64'(overflow_cnt), 64'd0);
    chk("rst_txn_id",     64'(rec_txn_id),   64'd0);
    chk("rst_latency",    64'(rec_latency),  64'd0);
    chk("rst_partial",    64'(rec_partial),  64'd0);
    reset = 1'b0;
  endtask

  // mode: 0 = ap_done closes, 1 = finish closes, 2 = both together
  task automatic run_txn(input int dlen, input int it_lo, input int it_hi,
                         input int st_lo, input int st_hi, input bit keep_start,
                         input int mode, input bit exp_push, input bit pop_at_end);
    logic [CW-1:0] el, ei, es;
    rec_t r;
    el = '0; ei = '0; es = '0;
    for (int c = 0; c <= dlen; c++) begin
      ap_start = (c == 0) || keep_start;
      iter_end = (c >= it_lo) && (c <= it_hi);
      stall    = (c >= st_lo) && (c <= st_hi);
      ap_done  = (c == dlen) && (mode != 1);
      finish   = (c == dlen) && (mode != 0);
      if (pop_at_end && c == dlen) rec_ready = 1'b1;
      if (c == 0) begin
        el = 1; ei = 0; es = 0;
      end else begin
        if (el != MAXV) el++;
        if (iter_end && ei != MAXV) ei++;
        if (stall && es != MAXV) es++;
      end
      if (c == dlen && exp_push) begin
        r.id = exp_id; r.lat = el; r.it = ei; r.st = es; r.partial = (mode == 1);
        q.push_back(r);
      end
      tick();
      if (c == 0) chk("busy_after_start", 64'(busy), 64'd1);
    end
    if (mode != 1) exp_id++;
    if (pop_at_end) rec_ready = 1'b0;
    chk("busy_after_end", 64'(busy), 64'd0);
    if (!keep_start) ap_start = 1'b0;
    ap_done = 1'b0; iter_end = 1'b0; stall = 1'b0; finish = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && q.size() != 0; i++) tick();
    chk("drain_qsize", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(rec_valid), 64'd0);
  endtask

  task automatic wait_all_done(input int max_cyc);
    for (int i = 0; i < max_cyc && all_done !== 1'b1; i++) tick();
    chk("all_done", 64'(all_done), 64'd1);
    chk("all_done_qsize", 64'(q.size()), 64'd0);
  endtask

  initial begin
    do_reset();

    // Single transaction: expect id 0, latency 10, iters 4, stalls 2
    rec_ready = 1'b1;
    run_txn(9, 2, 5, 3, 4, 1'b0, 0, 1'b1, 1'b0);
    chk("valid_after_push", 64'(rec_valid), 64'd1);
    wait_drain(10);

    // Back-to-back with ap_start held through done
    do_reset();
    rec_ready = 1'b1;
    run_txn(5, 1, 3, 2, 2, 1'b1, 0, 1'b1, 1'b0);
    run_txn(7, 2, 2, 1, 6, 1'b1, 0, 1'b1, 1'b0);
    ap_start = 1'b0;
    wait_drain(10);

    // Backpressure: six transactions, only four fit
    do_reset();
    for (int i = 0; i < 6; i++) run_txn(2 + i, 1, 1, 2, 2, 1'b0, 0, (i < 4), 1'b0);
    chk("ovf_after_6", 64'(overflow_cnt), 64'd2);
    chk("ovf_valid", 64'(rec_valid), 64'd1);
    tick(); tick(); tick();
    rec_ready = 1'b1;
    wait_drain(20);
    chk("ovf_kept", 64'(overflow_cnt), 64'd2);

    // Full FIFO, pop in the same cycle as a push: no drop
    do_reset();
    for (int i = 0; i < 4; i++) run_txn(3, 1, 2, 1, 1, 1'b0, 0, 1'b1, 1'b0);
    run_txn(3, 1, 1, 2, 2, 1'b0, 0, 1'b1, 1'b1);
    chk("full_pop_push_ovf", 64'(overflow_cnt), 64'd0);
    rec_ready = 1'b1;
    wait_drain(20);

    // Finish five cycles after start: partial record with latency 6
    do_reset();
    rec_ready = 1'b1;
    run_txn(5, 2, 3, 9, 9, 1'b0, 1, 1'b1, 1'b0);
    wait_all_done(20);
    ap_start = 1'b1;
    tick(); tick(); tick();
    chk("done_terminal_busy", 64'(busy), 64'd0);
    chk("done_terminal_all_done", 64'(all_done), 64'd1);
    ap_start = 1'b0;

    // ap_done and finish together: one complete record
    do_reset();
    rec_ready = 1'b1;
    run_txn(4, 1, 4, 1, 1, 1'b0, 2, 1'b1, 1'b0);
    wait_all_done(20);

    // Reset mid-transaction with two records buffered
    do_reset();
    run_txn(2, 1, 1, 1, 1, 1'b0, 0, 1'b1, 1'b0);
    run_txn(3, 1, 2, 2, 2, 1'b0, 0, 1'b1, 1'b0);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_valid", 64'(rec_valid), 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(rec_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    q.delete();
    exp_id = '0;
    reset = 1'b0;
    rec_ready = 1'b1;
    run_txn(3, 1, 1, 1, 1, 1'b0, 0, 1'b1, 1'b0);
    wait_drain(10);

    // Counter saturation (8-bit counters, 300-cycle transaction)
    do_reset();
    rec_ready = 1'b1;
    run_txn(300, 1, 300, 1, 300, 1'b0, 0, 1'b1, 1'b0);
    wait_drain(10);

    // finish while idle goes straight through FLUSH to DONE
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("idle_finish_busy", 64'(busy), 64'd0);
    wait_all_done(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
